counter_seq_ctrl: RTL and testbench

//  Command-driven sequencer for the 8-bit up/down counter. Accepts one command at a

---
 rtl/counter_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_ctrl
//  Description : Command-driven sequencer for an up/down counter. Each
//                accepted command reloads the counter, enables it for an
//                exact number of cycles, holds for a pause and then reports
//                the final count with a one-cycle done pulse.
//  Options     : COUNTER_SEQ_CHECK_EN - when defined, the final count is
//                compared with start +/- len and a sticky err flag is kept.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 8,
  parameter int PAUSE_W = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  // command port
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_start,
  input  logic               cmd_dir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [PAUSE_W-1:0] cmd_pause,
  input  logic               abort,
  // counter instance controls
  output logic               ctr_aresetn,
  output logic               ctr_enable,
  output logic               ctr_inc_dec,
  output logic [WIDTH-1:0]   ctr_start_value,
  input  logic [WIDTH-1:0]   count_out,
  // status
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   final_value,
  output logic               err
);

  // One down-counter serves both the run and the pause phase.
  localparam int CNT_W = (LEN_W > PAUSE_W) ? LEN_W : PAUSE_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [PAUSE_W-1:0] pause_q;
  logic               accept;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // Next-state and phase-length logic; a zero-length run or pause phase is
  // skipped entirely so the done pulse lands at T+2+len+pause.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (len_q != '0) begin
          state_nxt = S_RUN;
          cnt_nxt   = CNT_W'(len_q);
        end else if (pause_q != '0) begin
          state_nxt = S_PAUSE;
          cnt_nxt   = CNT_W'(pause_q);
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          if (pause_q != '0) begin
            state_nxt = S_PAUSE;
            cnt_nxt   = CNT_W'(pause_q);
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and phase down-counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Latch the phase lengths on the accept cycle; the command bus is free after.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q   <= '0;
      pause_q <= '0;
    end else if (accept) begin
      len_q   <= cmd_len;
      pause_q <= cmd_pause;
    end
  end

  // Counter controls are registered from the next state so they are
  // glitch-free and line up exactly with the LOAD and RUN cycles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctr_aresetn     <= 1'b0;
      ctr_enable      <= 1'b0;
      ctr_inc_dec     <= 1'b0;
      ctr_start_value <= '0;
    end else begin
      ctr_aresetn <= (state_nxt != S_LOAD);
      ctr_enable  <= (state_nxt == S_RUN);
      if (accept) begin
        ctr_start_value <= cmd_start;
        ctr_inc_dec     <= cmd_dir;
      end
    end
  end

  // Completion pulse during DONE and capture of the count seen in DONE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done        <= 1'b0;
      final_value <= '0;
    end else begin
      done <= (state_nxt == S_DONE);
      if (state == S_DONE) begin
        final_value <= count_out;
      end
    end
  end

`ifdef COUNTER_SEQ_CHECK_EN
  logic [WIDTH-1:0] len_ext;
  logic [WIDTH-1:0] expected;

  // start and direction are still held on the counter outputs in DONE.
  assign len_ext  = WIDTH'(len_q);
  assign expected = ctr_inc_dec ? (ctr_start_value - len_ext)
                                : (ctr_start_value + len_ext);

  // Sticky mismatch flag; cleared only when the next command is accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if ((state == S_DONE) && (count_out != expected)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_seq_ctrl
//  Description : Self-checking bench for counter_seq_ctrl with a simple
//                counter attached and a cycle-schedule reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_start = 8'h00;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_len = 8'h00;
  logic [7:0] cmd_pause = 8'h00;
  logic       abort = 1'b0;
  logic       ctr_aresetn;
  logic       ctr_enable;
  logic       ctr_inc_dec;
  logic [7:0] ctr_start_value;
  logic [7:0] count_out;
  logic       busy;
  logic       done;
  logic [7:0] final_value;
  logic       err;

  logic       inj = 1'b0;   // flips count_out bit 0 to provoke a mismatch
  logic [7:0] cnt = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  counter_seq_ctrl #(.WIDTH(8), .LEN_W(8), .PAUSE_W(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_pause(cmd_pause), .abort(abort),
    .ctr_aresetn(ctr_aresetn), .ctr_enable(ctr_enable), .ctr_inc_dec(ctr_inc_dec),
    .ctr_start_value(ctr_start_value), .count_out(count_out),
    .busy(busy), .done(done), .final_value(final_value), .err(err)
  );

  // Attached counter: loads start_value while its reset is low, counts when enabled.
  always @(posedge aclk) begin
    if (!ctr_aresetn) cnt <= ctr_start_value;
    else if (ctr_enable) cnt <= ctr_inc_dec ? cnt - 8'd1 : cnt + 8'd1;
  end
  assign count_out = cnt ^ {7'b0, inj};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_count(input logic [7:0] s, input logic d, input int n);
    logic [7:0] l;
    l = n[7:0];
    return d ? s - l : s + l;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  int         cyc = 0;
  bit         chk_en = 1'b0;
  bit         m_active = 1'b0;
  int         m_acc = 0;
  int         m_len = 0;
  int         m_pause = 0;
  logic [7:0] m_start = 8'h00;
  logic       m_dir = 1'b0;
  logic [7:0] m_final = 8'h00;
  logic       m_err = 1'b0;
  int         dut_done_cyc = -1;

  always @(negedge aclk) begin
    int r, tot;
    logic e_ready, e_busy, e_rstn, e_en, e_done, e_err;
    cyc = cyc + 1;
    if (done === 1'b1) dut_done_cyc = cyc;
    if (!aresetn) begin
      m_active = 1'b0; m_final = 8'h00; m_err = 1'b0; m_start = 8'h00; m_dir = 1'b0;
    end else if (chk_en) begin
      r = 0; tot = 0;
      if (m_active) begin
        r = cyc - m_acc;
        tot = 2 + m_len + m_pause;
        e_ready = 1'b0; e_busy = 1'b1;
        e_rstn = (r != 1);
        e_en = (r >= 2) && (r <= 1 + m_len);
        e_done = (r == tot);
      end else begin
        e_ready = 1'b1; e_busy = 1'b0; e_rstn = 1'b1; e_en = 1'b0; e_done = 1'b0;
      end
`ifdef COUNTER_SEQ_CHECK_EN
      e_err = m_err;
`else
      e_err = 1'b0;
`endif
      chk("cmd_ready", cmd_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("ctr_aresetn", ctr_aresetn, e_rstn);
      chk("ctr_enable", ctr_enable, e_en);
      chk("done", done, e_done);
      chk("ctr_start_value", ctr_start_value, m_start);
      chk("ctr_inc_dec", ctr_inc_dec, m_dir);
      chk("final_value", final_value, m_final);
      chk("err", err, e_err);
      // advance the model with this cycle's inputs
      if (m_active) begin
        if (r == tot) begin
          m_active = 1'b0;
          m_final = exp_count(m_start, m_dir, m_len) ^ {7'b0, inj};
          if (inj) m_err = 1'b1;
        end else if (abort) begin
          m_active = 1'b0;
        end
      end else if (cmd_valid) begin
        m_active = 1'b1; m_acc = cyc;
        m_start = cmd_start; m_dir = cmd_dir;
        m_len = int'(cmd_len); m_pause = int'(cmd_pause);
        m_err = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] s, input logic d, input logic [7:0] l,
                      input logic [7:0] p, output int acc);
    @(posedge aclk); #2;
    cmd_start = s; cmd_dir = d; cmd_len = l; cmd_pause = p; cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge aclk); #1;
      if (cmd_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
    @(posedge aclk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int acc, output int lat, output int n_en,
                           output int n_rl, output bit dec_run);
    lat = -1; n_en = 0; n_rl = 0; dec_run = 1'b1;
    for (int i = 0; i < 700; i++) begin
      @(negedge aclk); #1;
      if (ctr_enable) begin n_en++; if (!ctr_inc_dec) dec_run = 1'b0; end
      if (!ctr_aresetn) n_rl++;
      if (done) begin lat = cyc - acc; break; end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic reset_seq();
    chk_en = 1'b0;
    cmd_valid = 1'b0; abort = 1'b0; inj = 1'b0;
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    chk("rst ctr_aresetn", ctr_aresetn, 0);
    chk("rst ctr_enable", ctr_enable, 0);
    chk("rst ctr_inc_dec", ctr_inc_dec, 0);
    chk("rst ctr_start_value", ctr_start_value, 8'h00);
    chk("rst done", done, 0);
    chk("rst final_value", final_value, 8'h00);
    chk("rst err", err, 0);
    chk("rst busy", busy, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b1;
    #1;
    chk("ctr_aresetn before edge", ctr_aresetn, 0);
    @(posedge aclk); #1;
    chk("ctr_aresetn after edge", ctr_aresetn, 1);
    chk_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, acc2, lat, n_en, n_rl, first_done;
    bit dec_run;
    logic [7:0] fv_keep;

    reset_seq();

    // 1: plain count up with pause
    send(8'hAF, 1'b0, 8'd10, 8'd5, acc);
    wait_done(acc, lat, n_en, n_rl, dec_run);
    chk("t1 latency", lat, 17);
    chk("t1 enable cycles", n_en, 10);
    chk("t1 ctr reset cycles", n_rl, 1);
    @(posedge aclk); #1;
    chk("t1 final", final_value, 8'hB9);

    // 2: wrap upward, no pause
    send(8'hFE, 1'b0, 8'd4, 8'd0, acc);
    wait_done(acc, lat, n_en, n_rl, dec_run);
    chk("t2 latency", lat, 6);
    @(posedge aclk); #1;
    chk("t2 final", final_value, 8'h02);

    // 3: wrap downward
    send(8'h03, 1'b1, 8'd5, 8'd2, acc);
    wait_done(acc, lat, n_en, n_rl, dec_run);
    chk("t3 latency", lat, 9);
    chk("t3 inc_dec in run", dec_run, 1);
    @(posedge aclk); #1;
    chk("t3 final", final_value, 8'hFE);

    // 4: zero run and zero pause
    send(8'hC0, 1'b0, 8'd0, 8'd0, acc);
    wait_done(acc, lat, n_en, n_rl, dec_run);
    chk("t4 latency", lat, 2);
    chk("t4 enable cycles", n_en, 0);
    @(posedge aclk); #1;
    chk("t4 final", final_value, 8'hC0);

    // 5: abort during run
    fv_keep = final_value;
    first_done = dut_done_cyc;
    send(8'h10, 1'b0, 8'd20, 8'd3, acc);
    repeat (5) @(posedge aclk);
    #2; abort = 1'b1;
    @(negedge aclk); #1;
    chk("t5 enable before abort", ctr_enable, 1);
    @(posedge aclk); #2; abort = 1'b0;
    @(negedge aclk); #1;
    chk("t5 enable after abort", ctr_enable, 0);
    chk("t5 busy after abort", busy, 0);
    chk("t5 ready after abort", cmd_ready, 1);
    repeat (30) @(posedge aclk);
    #1;
    chk("t5 final unchanged", final_value, fv_keep);
    chk("t5 no done", dut_done_cyc, first_done);

    // 6: injected mismatch, then back-to-back commands
    inj = 1'b1;
    send(8'h20, 1'b0, 8'd3, 8'd1, acc);
    wait_done(acc, lat, n_en, n_rl, dec_run);
    @(posedge aclk); #1;
    inj = 1'b0;
`ifdef COUNTER_SEQ_CHECK_EN
    chk("t6 err set", err, 1);
`else
    chk("t6 err tied", err, 0);
`endif
    chk("t6 final", final_value, 8'h22);
    send(8'h40, 1'b1, 8'd2, 8'd0, acc);
    chk("t6 err cleared", err, 0);
    #2;
    cmd_start = 8'h50; cmd_dir = 1'b0; cmd_len = 8'd1; cmd_pause = 8'd1; cmd_valid = 1'b1;
    acc2 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk); #1;
      if (cmd_ready) begin acc2 = cyc; break; end
    end
    chk("b2b accept after done", acc2 - dut_done_cyc, 1);
    chk("b2b first latency", dut_done_cyc - acc, 4);
    @(posedge aclk); #2; cmd_valid = 1'b0;
    wait_done(acc2, lat, n_en, n_rl, dec_run);
    chk("b2b second latency", lat, 4);
    @(posedge aclk); #1;
    chk("b2b second final", final_value, 8'h51);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(posedge aclk); #2;
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_start = 8'($urandom);
      cmd_dir   = 1'($urandom);
      r = $urandom_range(0, 9);
      cmd_len   = (r == 0) ? 8'd0 : (r < 9) ? 8'($urandom_range(1, 12)) : 8'($urandom);
      r = $urandom_range(0, 9);
      cmd_pause = (r < 2) ? 8'd0 : (r < 9) ? 8'($urandom_range(1, 8)) : 8'($urandom);
      abort     = ($urandom_range(0, 29) == 0);
      inj       = ($urandom_range(0, 4) == 0);
    end
    @(posedge aclk); #2;
    cmd_valid = 1'b0; abort = 1'b0; inj = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge aclk); #1;
      if (!busy) break;
    end
    chk("drain idle", busy, 0);

    // reset asserted in the middle of a command
    send(8'h77, 1'b0, 8'd30, 8'd4, acc);
    repeat (5) @(posedge aclk);
    #1;
    chk("mid-cmd busy", busy, 1);
    reset_seq();
    repeat (5) @(posedge aclk);
    send(8'h01, 1'b1, 8'd2, 8'd0, acc);
    wait_done(acc, lat, n_en, n_rl, dec_run);
    chk("post-reset latency", lat, 4);
    @(posedge aclk); #1;
    chk("post-reset final", final_value, 8'hFF);

    repeat (3) @(posedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
